// File: rtl/iomem_pkg.sv
// Shared types and constants for the iomem bus master slice.
package iomem_pkg;

  // Master sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_POLL  = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5
  } iomem_state_t;

  localparam logic [3:0]  WSTRB_READ        = 4'h0;
  localparam logic [3:0]  WSTRB_FULL        = 4'hF;
  localparam logic [31:0] ACCEL_RESULT_ADDR = 32'h0400_0040;
  localparam logic [31:0] ACCEL_STATUS_ADDR = 32'h0400_0044;
  localparam logic [31:0] ADDR_STEP         = 32'd4;

endpackage

// File: rtl/iomem_txn_timer.sv
// Per-transaction wait counter: flags the last permitted wait cycle of a
// request that the responder has not yet accepted.
module iomem_txn_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: zero while no request is outstanding, +1 per stalled cycle
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The current stalled cycle is the TIMEOUT_CYCLES-th one
  assign expired = count && (cnt_q == LAST);

endmodule

// File: rtl/iomem_dma_master.sv
// Word-copy DMA master on the iomem bus with optional status polling.
//
// Bus handshake: a request is held (valid, addr, wstrb, wdata all stable)
// until the rising edge where iomem_valid=1 and iomem_ready=1; that edge
// completes it. iomem_valid is then low for exactly one GAP cycle before the
// next request. Read data is sampled only on the completing edge.
module iomem_dma_master
  import iomem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int LEN_W          = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               cfg_start,
  input  logic [31:0]        cfg_src_addr,
  input  logic [31:0]        cfg_dst_addr,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_src_inc,
  input  logic               cfg_poll_en,
  input  logic [31:0]        cfg_poll_addr,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [LEN_W-1:0]   words_done,
  output logic               iomem_valid,
  output logic [3:0]         iomem_wstrb,
  output logic [31:0]        iomem_addr,
  output logic [31:0]        iomem_wdata,
  input  logic               iomem_ready,
  input  logic [31:0]        iomem_rdata,
  output iomem_state_t       dbg_state
);

  iomem_state_t      state_q, state_d, gap_next_q, gap_next_d;
  logic [31:0]       src_q, src_d, dst_q, dst_d, poll_addr_q, poll_addr_d;
  logic [31:0]       data_q, data_d;
  logic [LEN_W-1:0]  len_q, len_d, words_done_q, words_done_d;
  logic              src_inc_q, src_inc_d, poll_en_q, poll_en_d;
  logic              busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic              valid_q, valid_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       addr_q, addr_d, wdata_q, wdata_d;
  logic              timer_expired;

  iomem_txn_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (!valid_q),
    .count   (valid_q && !iomem_ready),
    .expired (timer_expired)
  );

  // Sequencer next-state and registered-output computation
  always_comb begin
    state_d      = state_q;
    gap_next_d   = gap_next_q;
    src_d        = src_q;
    dst_d        = dst_q;
    poll_addr_d  = poll_addr_q;
    data_d       = data_q;
    len_d        = len_q;
    words_done_d = words_done_q;
    src_inc_d    = src_inc_q;
    poll_en_d    = poll_en_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    error_d      = error_q;
    valid_d      = valid_q;
    wstrb_d      = wstrb_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          src_d        = cfg_src_addr;
          dst_d        = cfg_dst_addr;
          poll_addr_d  = cfg_poll_addr;
          len_d        = cfg_len;
          src_inc_d    = cfg_src_inc;
          poll_en_d    = cfg_poll_en;
          words_done_d = '0;
          error_d      = 1'b0;
          if (cfg_len == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            busy_d  = 1'b1;
            valid_d = 1'b1;
            wstrb_d = WSTRB_READ;
            if (cfg_poll_en) begin
              state_d = ST_POLL;
              addr_d  = cfg_poll_addr;
            end else begin
              state_d = ST_READ;
              addr_d  = cfg_src_addr;
            end
          end
        end
      end
      ST_POLL, ST_READ, ST_WRITE: begin
        if (timer_expired) begin
          valid_d = 1'b0;
          error_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (iomem_ready) begin
          valid_d = 1'b0;
          state_d = ST_GAP;
          case (state_q)
            ST_POLL: gap_next_d = iomem_rdata[0] ? ST_READ : ST_POLL;
            ST_READ: begin
              data_d     = iomem_rdata;
              gap_next_d = ST_WRITE;
            end
            default: begin
              words_done_d = words_done_q + LEN_W'(1);
              dst_d        = dst_q + ADDR_STEP;
              if (src_inc_q) src_d = src_q + ADDR_STEP;
              gap_next_d   = poll_en_q ? ST_POLL : ST_READ;
              if ((words_done_q + LEN_W'(1)) == len_q) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
              end
            end
          endcase
        end
      end
      ST_GAP: begin
        state_d = gap_next_q;
        valid_d = 1'b1;
        case (gap_next_q)
          ST_POLL: begin
            addr_d  = poll_addr_q;
            wstrb_d = WSTRB_READ;
          end
          ST_READ: begin
            addr_d  = src_q;
            wstrb_d = WSTRB_READ;
          end
          default: begin
            addr_d  = dst_q;
            wdata_d = data_q;
            wstrb_d = WSTRB_FULL;
          end
        endcase
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any request in flight
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      gap_next_q   <= ST_READ;
      src_q        <= '0;
      dst_q        <= '0;
      poll_addr_q  <= '0;
      data_q       <= '0;
      len_q        <= '0;
      words_done_q <= '0;
      src_inc_q    <= 1'b0;
      poll_en_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      valid_q      <= 1'b0;
      wstrb_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      gap_next_q   <= gap_next_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      poll_addr_q  <= poll_addr_d;
      data_q       <= data_d;
      len_q        <= len_d;
      words_done_q <= words_done_d;
      src_inc_q    <= src_inc_d;
      poll_en_q    <= poll_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      valid_q      <= valid_d;
      wstrb_q      <= wstrb_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign words_done  = words_done_q;
  assign iomem_valid = valid_q;
  assign iomem_wstrb = wstrb_q;
  assign iomem_addr  = addr_q;
  assign iomem_wdata = wdata_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/iomem_dma_master.md
IOMEM_DMA_MASTER -- requirements
Module: iomem_dma_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning max wait cycles for iomem_ready per transaction.
REQ-002 SHALL have parameter LEN_W, default 16, meaning width of the transfer length and progress counters.
REQ-003 clk  input  1  clock; all logic rising-edge.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 cfg_start  input  1  single-cycle start request.
REQ-006 cfg_src_addr  input  32  source word address.
REQ-007 cfg_dst_addr  input  32  destination word address.
REQ-008 cfg_len  input  LEN_W  number of 32-bit words to move.
REQ-009 cfg_src_inc  input  1  1: src += 4 per word; 0: fixed src (FIFO pop port).
REQ-010 cfg_poll_en  input  1  1: read cfg_poll_addr before each word and wait for bit0=1.
REQ-011 cfg_poll_addr  input  32  status register address.
REQ-012 busy  output  1  high from start acceptance until DONE.
REQ-013 done  output  1  one-cycle pulse at completion or abort.
REQ-014 error  output  1  timeout flag, held until next accepted start.
REQ-015 words_done  output  LEN_W  words written so far.
REQ-016 iomem_valid  output  1  bus request.
REQ-017 iomem_wstrb  output  4  0 = read, 4'hF = write.
REQ-018 iomem_addr  output  32  transaction address.
REQ-019 iomem_wdata  output  32  write data.
REQ-020 iomem_ready  input  1  responder completion; may be combinational from iomem_valid.
REQ-021 iomem_rdata  input  32  read data, valid only when iomem_ready=1.

Function
REQ-022 FSM states SHALL be IDLE, POLL, READ, WRITE, GAP, DONE.
REQ-023 cfg_start SHALL be accepted only in IDLE: latches all cfg_* inputs, clears words_done and error, sets busy; ignored otherwise.
REQ-024 Accepted start with cfg_len=0 SHALL go directly to DONE with no bus activity.
REQ-025 Otherwise, the next state SHALL be POLL if cfg_poll_en=1, else READ.
REQ-026 All iomem_* outputs SHALL be registered; addr/wstrb/wdata stable while iomem_valid=1 and ready=0.
REQ-027 A transaction SHALL complete at the rising edge where iomem_valid=1 and iomem_ready=1; iomem_valid SHALL be low on the following cycle (GAP, exactly one cycle) before any new request.
REQ-028 POLL: read cfg_poll_addr; on completion, rdata[0]=1 -> READ, rdata[0]=0 -> GAP then POLL again.
REQ-029 READ: read src; capture iomem_rdata into data register on completion, then GAP -> WRITE.
REQ-030 WRITE: write data register to dst with wstrb 4'hF; on completion words_done+1, dst+4, src+4 if cfg_src_inc.
REQ-031 After WRITE, if words_done equals cfg_len then DONE, else GAP -> POLL/READ per cfg_poll_en.
REQ-032 Address increment SHALL wrap modulo 2^32 with no error.
REQ-033 A per-transaction wait counter SHALL clear at each request and increment each cycle ready=0; at TIMEOUT_CYCLES, drop iomem_valid, set error, go to DONE.
REQ-034 DONE SHALL pulse done for one cycle, clear busy, return to IDLE; cfg_start in DONE is ignored.
REQ-035 Latency SHALL be minimal: with ready same-cycle, no poll, each word takes 4 cycles (READ, GAP, WRITE, GAP).

Reset
REQ-036 resetn=0 SHALL force IDLE, busy=0, done=0, error=0, words_done=0, iomem_valid=0, wstrb=0, addr=0, wdata=0 on the next edge, aborting any transaction in flight.
REQ-037 Reset SHALL take priority over cfg_start and iomem_ready in the same cycle.

Structure
REQ-038 Shared package iomem_pkg SHALL hold the FSM state typedef, WSTRB_READ=4'h0, WSTRB_FULL=4'hF, ACCEL_RESULT_ADDR=32'h0400_0040, ACCEL_STATUS_ADDR=32'h0400_0044.
REQ-039 The wait counter SHALL be one sub-module, iomem_txn_timer (clear, count, expired).

Verification
REQ-040 src=0x0400_0040, inc=0, poll on 0x0400_0044, len=3, responder FIFO 0xA1,0xB2,0xC3, dst=0x0000_1000 -> writes to 0x1000/0x1004/0x1008 in order, words_done=3, one done pulse, error=0.
REQ-041 Same-cycle ready, no poll, inc=1, len=2 -> valid pattern 1,0,1,0,1,0,1,0; done on cycle 9 after start; valid never high two consecutive cycles.
REQ-042 Status reads 0 for 5 polls then 1 -> exactly 6 POLL reads before first READ, no source read while status=0.
REQ-043 TIMEOUT_CYCLES=8, responder never ready -> valid drops after 8 wait cycles, error=1, done pulse, busy=0; next start clears error.
REQ-044 len=0 -> done pulse, no iomem_valid; cfg_start while busy -> ignored, cfg latch unchanged.
REQ-045 resetn low during WRITE wait -> next cycle all outputs 0, IDLE; new start runs cleanly from words_done=0.
